// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared types for the rename-to-dispatch group buffer.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
`ifndef PREG_INDEX_WIDTH
`define PREG_INDEX_WIDTH 6
`endif

package dispatch_pkg;

  localparam int DISP_WIDTH  = 4;
  localparam int DISP_PREG_W = `PREG_INDEX_WIDTH;

  typedef logic [DISP_PREG_W-1:0] preg_t;

  // One renamed instruction as held in the buffer, including its live operand-ready state.
  typedef struct packed {
    logic [31:0] pc;
    logic        rd_ex;
    logic        rj_ex;
    logic        rk_ex;
    logic [4:0]  rd_arch;
    preg_t       prd;
    preg_t       prj;
    preg_t       prk;
    preg_t       prd_old;
    logic        rj_rdy;
    logic        rk_rdy;
  } disp_slot_t;

  typedef struct packed {
    logic [DISP_WIDTH-1:0]        slot_vld;
    disp_slot_t [DISP_WIDTH-1:0]  slot;
  } disp_group_t;

  // Number of valid slots in a group, i.e. the ROB entries it will consume.
  function automatic logic [2:0] slot_count(input logic [DISP_WIDTH-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < DISP_WIDTH; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/disp_wakeup_match.sv
// disp_wakeup_match: compares 4 writeback pregs against 8 source pregs (4 rj then 4 rk).
// Latency: combinational.
// Backpressure: none; pure compare.
module disp_wakeup_match
  import dispatch_pkg::*;
(
  input  logic [DISP_WIDTH-1:0]   wb_valid,
  input  preg_t [DISP_WIDTH-1:0]  wb_preg,
  input  preg_t [2*DISP_WIDTH-1:0] src_preg,
  output logic [2*DISP_WIDTH-1:0] hit
);

  // A source is hit when any valid writeback port carries its preg index.
  always_comb begin
    hit = '0;
    for (int s = 0; s < 2*DISP_WIDTH; s++) begin
      for (int k = 0; k < DISP_WIDTH; k++) begin
        if (wb_valid[k] && (wb_preg[k] == src_preg[s])) begin
          hit[s] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dispatch_buffer.sv
// dispatch_buffer: 4-wide rename->dispatch group FIFO that keeps operand ready bits current.
// Latency: enqueue to out_valid 1 cycle; 0 cycles from an empty buffer when DISPATCH_BYPASS_EN is defined.
// Backpressure: in_ready is registered (count < DEPTH); head waits for iq_ready and ROB room for all valid slots.
`ifndef PREG_INDEX_WIDTH
`define PREG_INDEX_WIDTH 6
`endif

module dispatch_buffer
  import dispatch_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PREG_W    = `PREG_INDEX_WIDTH,
  parameter int ROB_CNT_W = 7
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DISP_WIDTH-1:0]                 in_slot_vld,
  input  logic [DISP_WIDTH-1:0][31:0]           in_pc,
  input  logic [DISP_WIDTH-1:0]                 in_rd_ex,
  input  logic [DISP_WIDTH-1:0]                 in_rj_ex,
  input  logic [DISP_WIDTH-1:0]                 in_rk_ex,
  input  logic [DISP_WIDTH-1:0][4:0]            in_rd_arch,
  input  logic [DISP_WIDTH-1:0][PREG_W-1:0]     in_prd,
  input  logic [DISP_WIDTH-1:0][PREG_W-1:0]     in_prj,
  input  logic [DISP_WIDTH-1:0][PREG_W-1:0]     in_prk,
  input  logic [DISP_WIDTH-1:0][PREG_W-1:0]     in_prd_old,
  input  logic [DISP_WIDTH-1:0]                 in_rj_busy,
  input  logic [DISP_WIDTH-1:0]                 in_rk_busy,
  input  logic [DISP_WIDTH-1:0]                 wb_valid,
  input  logic [DISP_WIDTH-1:0][PREG_W-1:0]     wb_preg,
  input  logic [ROB_CNT_W-1:0]                  rob_free_cnt,
  input  logic                                  iq_ready,
  output logic                                  out_valid,
  output logic                                  out_fire,
  output logic [DISP_WIDTH-1:0]                 out_slot_vld,
  output logic [DISP_WIDTH-1:0][31:0]           out_pc,
  output logic [DISP_WIDTH-1:0]                 out_rd_ex,
  output logic [DISP_WIDTH-1:0]                 out_rj_ex,
  output logic [DISP_WIDTH-1:0]                 out_rk_ex,
  output logic [DISP_WIDTH-1:0][4:0]            out_rd_arch,
  output logic [DISP_WIDTH-1:0][PREG_W-1:0]     out_prd,
  output logic [DISP_WIDTH-1:0][PREG_W-1:0]     out_prj,
  output logic [DISP_WIDTH-1:0][PREG_W-1:0]     out_prk,
  output logic [DISP_WIDTH-1:0][PREG_W-1:0]     out_prd_old,
  output logic [DISP_WIDTH-1:0]                 out_rj_rdy,
  output logic [DISP_WIDTH-1:0]                 out_rk_rdy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  disp_group_t mem     [DEPTH];
  disp_group_t mem_nxt [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;
  logic             in_ready_q;

  disp_group_t in_grp;
  disp_group_t head_grp;
  disp_group_t sel_grp;
  disp_group_t out_grp;

  logic empty, has_slots, enq_fire, byp_cand, head_vld, rob_ok, fire, deq, store;
  logic dep_j, dep_k;

  preg_t [2*DISP_WIDTH-1:0] in_src;
  logic  [2*DISP_WIDTH-1:0] in_hit;
  preg_t [2*DISP_WIDTH-1:0] ent_src [DEPTH];
  logic  [2*DISP_WIDTH-1:0] ent_hit [DEPTH];

  assign empty     = (count == '0);
  assign has_slots = |in_slot_vld;
  assign enq_fire  = in_valid && in_ready_q;
  assign in_ready  = in_ready_q;
  assign head_grp  = mem[rd_ptr];

  // Source list for the incoming group's wakeup compare.
  always_comb begin
    in_src = '0;
    for (int i = 0; i < DISP_WIDTH; i++) begin
      in_src[i]            = in_prj[i];
      in_src[DISP_WIDTH+i] = in_prk[i];
    end
  end

  disp_wakeup_match u_in_match (
    .wb_valid (wb_valid),
    .wb_preg  (wb_preg),
    .src_preg (in_src),
    .hit      (in_hit)
  );

  // Build the group as it will be stored: an older in-group producer beats both busy-table and same-cycle writeback.
  always_comb begin
    in_grp          = '0;
    dep_j           = 1'b0;
    dep_k           = 1'b0;
    in_grp.slot_vld = in_slot_vld;
    for (int i = 0; i < DISP_WIDTH; i++) begin
      dep_j = 1'b0;
      dep_k = 1'b0;
      for (int s = 0; s < DISP_WIDTH; s++) begin
        if ((s < i) && in_slot_vld[s] && in_rd_ex[s]) begin
          if (in_prd[s] == in_prj[i]) dep_j = 1'b1;
          if (in_prd[s] == in_prk[i]) dep_k = 1'b1;
        end
      end
      in_grp.slot[i].pc      = in_pc[i];
      in_grp.slot[i].rd_ex   = in_rd_ex[i];
      in_grp.slot[i].rj_ex   = in_rj_ex[i];
      in_grp.slot[i].rk_ex   = in_rk_ex[i];
      in_grp.slot[i].rd_arch = in_rd_arch[i];
      in_grp.slot[i].prd     = in_prd[i];
      in_grp.slot[i].prj     = in_prj[i];
      in_grp.slot[i].prk     = in_prk[i];
      in_grp.slot[i].prd_old = in_prd_old[i];
      in_grp.slot[i].rj_rdy  = !in_rj_ex[i] || (in_prj[i] == '0) ||
                               (!dep_j && (!in_rj_busy[i] || in_hit[i]));
      in_grp.slot[i].rk_rdy  = !in_rk_ex[i] || (in_prk[i] == '0) ||
                               (!dep_k && (!in_rk_busy[i] || in_hit[DISP_WIDTH+i]));
    end
  end

  // Source list per held entry for writeback wakeup.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      ent_src[e] = '0;
      for (int i = 0; i < DISP_WIDTH; i++) begin
        ent_src[e][i]            = mem[e].slot[i].prj;
        ent_src[e][DISP_WIDTH+i] = mem[e].slot[i].prk;
      end
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_wake
    disp_wakeup_match u_match (
      .wb_valid (wb_valid),
      .wb_preg  (wb_preg),
      .src_preg (ent_src[e]),
      .hit      (ent_hit[e])
    );
  end

`ifdef DISPATCH_BYPASS_EN
  // An empty buffer presents the incoming group directly so it can leave in its arrival cycle.
  assign byp_cand = empty && in_valid && has_slots && !flush;
`else
  assign byp_cand = 1'b0;
`endif

  assign head_vld = !empty || byp_cand;
  assign sel_grp  = byp_cand ? in_grp : head_grp;
  assign rob_ok   = (rob_free_cnt >= ROB_CNT_W'(slot_count(sel_grp.slot_vld)));
  assign fire     = head_vld && iq_ready && rob_ok && !flush;
  assign deq      = fire && !empty;
  // A group that left through the bypass is never written; empty-slot groups are dropped.
  assign store    = enq_fire && has_slots && !(fire && empty);

  // Occupancy after this cycle's store/dispatch.
  always_comb begin
    count_nxt = count;
    if (store && !deq) begin
      count_nxt = count + CNT_ONE;
    end else if (!store && deq) begin
      count_nxt = count - CNT_ONE;
    end
  end

  // Held entries accumulate wakeups; the write slot takes the new group.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      mem_nxt[e] = mem[e];
      for (int i = 0; i < DISP_WIDTH; i++) begin
        mem_nxt[e].slot[i].rj_rdy = mem[e].slot[i].rj_rdy | ent_hit[e][i];
        mem_nxt[e].slot[i].rk_rdy = mem[e].slot[i].rk_rdy | ent_hit[e][DISP_WIDTH+i];
      end
    end
    if (store) begin
      mem_nxt[wr_ptr] = in_grp;
    end
  end

  // Entry storage; contents are don't-care while not counted, outputs are masked instead.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      mem[e] <= mem_nxt[e];
    end
  end

  // Pointers, occupancy and the registered ready; flush empties the buffer outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_ONE;
      if (deq)   rd_ptr <= rd_ptr + PTR_ONE;
      count      <= count_nxt;
      in_ready_q <= (count_nxt < CNT_FULL);
    end
  end

  assign out_valid = head_vld;
  assign out_fire  = fire;
  assign out_grp   = head_vld ? sel_grp : '0;

  // Unpack the presented group onto the flat output ports.
  always_comb begin
    out_slot_vld = out_grp.slot_vld;
    for (int i = 0; i < DISP_WIDTH; i++) begin
      out_pc[i]      = out_grp.slot[i].pc;
      out_rd_ex[i]   = out_grp.slot[i].rd_ex;
      out_rj_ex[i]   = out_grp.slot[i].rj_ex;
      out_rk_ex[i]   = out_grp.slot[i].rk_ex;
      out_rd_arch[i] = out_grp.slot[i].rd_arch;
      out_prd[i]     = out_grp.slot[i].prd;
      out_prj[i]     = out_grp.slot[i].prj;
      out_prk[i]     = out_grp.slot[i].prk;
      out_prd_old[i] = out_grp.slot[i].prd_old;
      out_rj_rdy[i]  = out_grp.slot[i].rj_rdy;
      out_rk_rdy[i]  = out_grp.slot[i].rk_rdy;
    end
  end

endmodule

// File: tb/tb_dispatch_buffer.sv
// tb_dispatch_buffer: directed scenarios plus random traffic against a queue-based reference model.
// Latency: checks every cycle at negedge+1.
// Backpressure: iq_ready and rob_free_cnt are driven both directed and random.
`timescale 1ns/1ps

module tb_dispatch_buffer;
  import dispatch_pkg::*;

  localparam int DEPTH     = 4;
  localparam int PREG_W    = DISP_PREG_W;
  localparam int ROB_CNT_W = 7;
  localparam int W         = DISP_WIDTH;
`ifdef DISPATCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, iq_ready, out_valid, out_fire;
  logic [W-1:0] in_slot_vld, in_rd_ex, in_rj_ex, in_rk_ex, in_rj_busy, in_rk_busy, wb_valid;
  logic [W-1:0][31:0] in_pc, out_pc;
  logic [W-1:0][4:0]  in_rd_arch, out_rd_arch;
  logic [W-1:0][PREG_W-1:0] in_prd, in_prj, in_prk, in_prd_old, wb_preg;
  logic [W-1:0][PREG_W-1:0] out_prd, out_prj, out_prk, out_prd_old;
  logic [ROB_CNT_W-1:0] rob_free_cnt;
  logic [W-1:0] out_slot_vld, out_rd_ex, out_rj_ex, out_rk_ex, out_rj_rdy, out_rk_rdy;

  int n_vec  = 0;
  int n_miss = 0;
  disp_group_t q[$];

  always #5 clk = ~clk;

  dispatch_buffer #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ROB_CNT_W(ROB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_slot_vld(in_slot_vld), .in_pc(in_pc), .in_rd_ex(in_rd_ex), .in_rj_ex(in_rj_ex),
    .in_rk_ex(in_rk_ex), .in_rd_arch(in_rd_arch), .in_prd(in_prd), .in_prj(in_prj),
    .in_prk(in_prk), .in_prd_old(in_prd_old), .in_rj_busy(in_rj_busy), .in_rk_busy(in_rk_busy),
    .wb_valid(wb_valid), .wb_preg(wb_preg), .rob_free_cnt(rob_free_cnt), .iq_ready(iq_ready),
    .out_valid(out_valid), .out_fire(out_fire), .out_slot_vld(out_slot_vld), .out_pc(out_pc),
    .out_rd_ex(out_rd_ex), .out_rj_ex(out_rj_ex), .out_rk_ex(out_rk_ex),
    .out_rd_arch(out_rd_arch), .out_prd(out_prd), .out_prj(out_prj), .out_prk(out_prk),
    .out_prd_old(out_prd_old), .out_rj_rdy(out_rj_rdy), .out_rk_rdy(out_rk_rdy)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Operand is ready unless it exists, is not preg 0, and either an older valid
  // slot of the same group writes it or the busy table says busy with no writeback hit.
  function automatic bit src_ready(int i, logic [PREG_W-1:0] p, bit ex, bit busy);
    bit dep = 0;
    bit hit = 0;
    for (int s = 0; s < i; s++)
      if (in_slot_vld[s] && in_rd_ex[s] && in_prd[s] == p) dep = 1;
    for (int k = 0; k < W; k++)
      if (wb_valid[k] && wb_preg[k] == p) hit = 1;
    return !ex || (p == 0) || (!dep && (!busy || hit));
  endfunction

  function automatic disp_group_t build_grp();
    disp_group_t g;
    g = '0;
    g.slot_vld = in_slot_vld;
    for (int i = 0; i < W; i++) begin
      g.slot[i].pc      = in_pc[i];
      g.slot[i].rd_ex   = in_rd_ex[i];
      g.slot[i].rj_ex   = in_rj_ex[i];
      g.slot[i].rk_ex   = in_rk_ex[i];
      g.slot[i].rd_arch = in_rd_arch[i];
      g.slot[i].prd     = in_prd[i];
      g.slot[i].prj     = in_prj[i];
      g.slot[i].prk     = in_prk[i];
      g.slot[i].prd_old = in_prd_old[i];
      g.slot[i].rj_rdy  = src_ready(i, in_prj[i], in_rj_ex[i], in_rj_busy[i]);
      g.slot[i].rk_rdy  = src_ready(i, in_prk[i], in_rk_ex[i], in_rk_busy[i]);
    end
    return g;
  endfunction

  function automatic bit wb_hits(logic [PREG_W-1:0] p);
    for (int k = 0; k < W; k++)
      if (wb_valid[k] && wb_preg[k] == p) return 1;
    return 0;
  endfunction

  // One clock: compare outputs against the model, then advance the model with the same inputs.
  task automatic cycle();
    disp_group_t head, exp, t;
    bit hv, fire, byp, exp_rdy;
    logic [W-1:0][31:0] e_pc;
    logic [W-1:0][4:0] e_arch;
    logic [W-1:0][PREG_W-1:0] e_prd, e_prj, e_prk, e_old;
    logic [W-1:0] e_rdex, e_rjex, e_rkex, e_rjr, e_rkr;
    #1;
    byp = 0;
    if (q.size() > 0) begin
      hv = 1; head = q[0];
    end else if (BYPASS && in_valid && in_slot_vld != 0 && !flush) begin
      hv = 1; head = build_grp(); byp = 1;
    end else begin
      hv = 0; head = '0;
    end
    fire    = hv && iq_ready && (int'(rob_free_cnt) >= $countones(head.slot_vld)) && !flush;
    exp_rdy = (q.size() < DEPTH);
    exp     = hv ? head : '0;
    for (int i = 0; i < W; i++) begin
      e_pc[i] = exp.slot[i].pc;       e_arch[i] = exp.slot[i].rd_arch;
      e_prd[i] = exp.slot[i].prd;     e_prj[i] = exp.slot[i].prj;
      e_prk[i] = exp.slot[i].prk;     e_old[i] = exp.slot[i].prd_old;
      e_rdex[i] = exp.slot[i].rd_ex;  e_rjex[i] = exp.slot[i].rj_ex;
      e_rkex[i] = exp.slot[i].rk_ex;  e_rjr[i] = exp.slot[i].rj_rdy;
      e_rkr[i] = exp.slot[i].rk_rdy;
    end
    check_val("in_ready", in_ready, exp_rdy);
    check_val("out_valid", out_valid, hv);
    check_val("out_fire", out_fire, fire);
    check_val("slot_vld", out_slot_vld, exp.slot_vld);
    check_val("pc", out_pc, e_pc);
    check_val("rd_arch", out_rd_arch, e_arch);
    check_val("ex_bits", {out_rd_ex, out_rj_ex, out_rk_ex}, {e_rdex, e_rjex, e_rkex});
    check_val("pregs", {out_prd, out_prj, out_prk, out_prd_old}, {e_prd, e_prj, e_prk, e_old});
    check_val("rj_rdy", out_rj_rdy, e_rjr);
    check_val("rk_rdy", out_rk_rdy, e_rkr);
    if (flush) begin
      q.delete();
    end else begin
      if (fire && !byp) void'(q.pop_front());
      for (int j = 0; j < q.size(); j++) begin
        t = q[j];
        for (int i = 0; i < W; i++) begin
          if (wb_hits(t.slot[i].prj)) t.slot[i].rj_rdy = 1'b1;
          if (wb_hits(t.slot[i].prk)) t.slot[i].rk_rdy = 1'b1;
        end
        q[j] = t;
      end
      if (in_valid && exp_rdy && in_slot_vld != 0 && !(byp && fire)) q.push_back(build_grp());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; wb_valid = '0; iq_ready = 1; rob_free_cnt = 7'd8;
  endtask

  task automatic rand_group(input logic [W-1:0] vld);
    in_slot_vld = vld;
    for (int i = 0; i < W; i++) begin
      in_pc[i]      = $urandom;
      in_rd_arch[i] = 5'($urandom);
      in_prd[i]     = PREG_W'($urandom_range(1, 15));
      in_prj[i]     = PREG_W'($urandom_range(0, 15));
      in_prk[i]     = PREG_W'($urandom_range(0, 15));
      in_prd_old[i] = PREG_W'($urandom_range(0, 63));
    end
    in_rd_ex = 4'($urandom); in_rj_ex = 4'($urandom); in_rk_ex = 4'($urandom);
    in_rj_busy = 4'($urandom); in_rk_busy = 4'($urandom);
  endtask

  task automatic rand_wb();
    wb_valid = 4'($urandom) & 4'($urandom);
    for (int k = 0; k < W; k++) wb_preg[k] = PREG_W'($urandom_range(0, 15));
  endtask

  initial begin
    rst_n = 0; idle(); rand_group(4'b0000); wb_preg = '0;
    #12;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_fire", out_fire, 1'b0);
    check_val("rst_in_ready", in_ready, 1'b1);
    check_val("rst_fields", {out_slot_vld, out_prd, out_pc}, '0);
    @(negedge clk); rst_n = 1;
    cycle();

    // Full group, free ROB and IQ: visible and dispatched the cycle after enqueue.
    rand_group(4'b1111);
    for (int i = 0; i < W; i++) in_prd[i] = PREG_W'(10 + i);
    in_valid = 1; cycle();
    in_valid = 0; cycle(); cycle();

    // In-group dependency keeps slot1's rj not ready until preg 10 writes back.
    iq_ready = 0; rand_group(4'b1111);
    in_prd[0] = 10; in_rd_ex[0] = 1; in_prj[1] = 10; in_rj_ex[1] = 1; in_rj_busy[1] = 0;
    in_valid = 1; cycle();
    in_valid = 0; cycle();
    check_val("dep_hold", out_rj_rdy[1], 1'b0);
    wb_valid = 4'b0001; wb_preg[0] = 10; cycle();
    wb_valid = '0;
    check_val("dep_wake", out_rj_rdy[1], 1'b1);
    iq_ready = 1; cycle(); cycle();

    // Fill to DEPTH under IQ backpressure, then drain in order.
    iq_ready = 0;
    for (int n = 0; n < DEPTH + 1; n++) begin
      rand_group(4'($urandom_range(1, 15))); in_valid = 1; cycle();
    end
    check_val("full_in_ready", in_ready, 1'b0);
    in_valid = 0; iq_ready = 1;
    for (int n = 0; n < DEPTH + 1; n++) cycle();

    // ROB room boundary: three valid slots need three free entries.
    rob_free_cnt = 7'd2; rand_group(4'b0111); in_valid = 1; cycle();
    in_valid = 0; cycle(); cycle();
    check_val("rob_short_hold", out_valid, 1'b1);
    rob_free_cnt = 7'd3; cycle(); cycle();

    // Flush with three held groups and a concurrent enqueue.
    idle(); iq_ready = 0;
    for (int n = 0; n < 3; n++) begin
      rand_group(4'b1011); in_valid = 1; cycle();
    end
    flush = 1; rand_group(4'b1111); in_valid = 1; cycle();
    flush = 0; in_valid = 0; cycle();
    rand_group(4'b0001); in_valid = 1; cycle();
    in_valid = 0; iq_ready = 1; cycle(); cycle();

    // Dropped empty-slot group and asynchronous reset with groups held.
    rand_group(4'b0000); in_valid = 1; cycle();
    iq_ready = 0; rand_group(4'b1100); cycle(); cycle();
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    check_val("arst_out_valid", out_valid, 1'b0);
    check_val("arst_in_ready", in_ready, 1'b1);
    q.delete();
    @(negedge clk); rst_n = 1; iq_ready = 1;
    cycle();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      rand_group(($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)));
      in_valid     = ($urandom_range(0, 3) != 0);
      iq_ready     = ($urandom_range(0, 9) < 7);
      rob_free_cnt = 7'($urandom_range(0, 8));
      flush        = ($urandom_range(0, 39) == 0);
      rand_wb();
      cycle();
    end
    idle();
    for (int n = 0; n < DEPTH + 2; n++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
